// File: rtl/pixel_data_packer.sv
// Samples NCH parallel channels, optionally waits for a repeated header pattern,
// and packs SPW samples per FIFO word tagged with a 4-bit rolling word index.
//   state     | meaning
//   S_IDLE    | waiting for start
//   S_SEARCH  | looking for HDR_REPEAT consecutive HEADER samples
//   S_CAPTURE | packing samples into words until NDATA words produced
//   S_DONE    | one-cycle done pulse, then back to idle
module pixel_data_packer #(
    parameter int NCH = 8,
    parameter int FIFO_WIDTH = 36,
    parameter int NDATA = 100,
    parameter logic [NCH-1:0] HEADER = 8'h5A,
    parameter int HDR_REPEAT = 2,
    parameter int TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  mode,
    input  logic [NCH-1:0]        din,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_flag,
    output logic [15:0]           drop_cnt
);

    localparam int SPW = (FIFO_WIDTH - 4) / NCH;
    localparam int PW  = SPW * NCH;
    localparam int SCW = (SPW > 1) ? $clog2(SPW) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_CAPTURE, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              hdr_cnt_q, hdr_cnt_d;
    logic [31:0]             tmo_q, tmo_d;
    logic [SCW-1:0]          samp_cnt_q, samp_cnt_d;
    logic [PW-1:0]           pack_q, pack_d;
    logic [3:0]              word_idx_q, word_idx_d;
    logic [15:0]             word_rem_q, word_rem_d;
    logic [FIFO_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    wr_en_q, wr_en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    tmo_flag_q, tmo_flag_d;
    logic [15:0]             drop_cnt_q, drop_cnt_d;
    logic [PW-1:0]           full_word;

    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        tmo_d      = tmo_q;
        samp_cnt_d = samp_cnt_q;
        pack_d     = pack_q;
        word_idx_d = word_idx_q;
        word_rem_d = word_rem_q;
        data_out_d = data_out_q;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;
        tmo_flag_d = tmo_flag_q;
        drop_cnt_d = drop_cnt_q;

        full_word = pack_q;
        full_word[int'(samp_cnt_q)*NCH +: NCH] = din;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    drop_cnt_d = '0;
                    tmo_flag_d = 1'b0;
                    hdr_cnt_d  = '0;
                    tmo_d      = 32'(TIMEOUT - 1);
                    samp_cnt_d = '0;
                    pack_d     = '0;
                    word_idx_d = '0;
                    word_rem_d = 16'(NDATA);
                    state_d    = mode ? S_CAPTURE : S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (din == HEADER && hdr_cnt_q == 4'(HDR_REPEAT - 1)) begin
                    state_d = S_CAPTURE;
                end else begin
                    hdr_cnt_d = (din == HEADER) ? hdr_cnt_q + 4'd1 : 4'd0;
                    if (TIMEOUT != 0 && tmo_q == 32'd0) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        tmo_flag_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q - 32'd1;
                    end
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (word_rem_q == 16'd0) begin
                    // the last word's strobe cycle has passed; finish now
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (samp_cnt_q == SCW'(SPW - 1)) begin
                    samp_cnt_d = '0;
                    pack_d     = '0;
                    word_idx_d = word_idx_q + 4'd1;
                    word_rem_d = word_rem_q - 16'd1;
                    if (!fifo_full) begin
                        data_out_d = '0;
                        data_out_d[PW-1:0] = full_word;
                        data_out_d[FIFO_WIDTH-1 -: 4] = word_idx_q;
                        wr_en_d = 1'b1;
                    end else if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end else begin
                    pack_d     = full_word;
                    samp_cnt_d = samp_cnt_q + SCW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_SEARCH) || (state_d == S_CAPTURE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            hdr_cnt_q  <= '0;
            tmo_q      <= '0;
            samp_cnt_q <= '0;
            pack_q     <= '0;
            word_idx_q <= '0;
            word_rem_q <= '0;
            data_out_q <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tmo_flag_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            tmo_q      <= tmo_d;
            samp_cnt_q <= samp_cnt_d;
            pack_q     <= pack_d;
            word_idx_q <= word_idx_d;
            word_rem_q <= word_rem_d;
            data_out_q <= data_out_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tmo_flag_q <= tmo_flag_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign data_out     = data_out_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timeout_flag = tmo_flag_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_pixel_data_packer.sv
// Scoreboard bench for pixel_data_packer: expected words are queued as stimulus
// is driven and popped whenever the DUT strobes fifo_wr_en.
module tb_pixel_data_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [35:0] data_out;
    logic        busy;
    logic        done;
    logic        timeout_flag;
    logic [15:0] drop_cnt;

    pixel_data_packer #(
        .NCH(8), .FIFO_WIDTH(36), .NDATA(3), .HEADER(8'h5A),
        .HDR_REPEAT(2), .TIMEOUT(10)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .din(din), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .data_out(data_out), .busy(busy), .done(done),
        .timeout_flag(timeout_flag), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [35:0] exp_q[$];
    int wr_cyc[$];
    int n_wr = 0, n_done = 0, done_cyc = 0;
    int n_checks = 0, n_errs = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fifo_wr_en) begin
            n_wr++;
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) check_val("unexpected_write", 64'(data_out), 64'h0);
            else check_val("word", 64'(data_out), 64'(exp_q.pop_front()));
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    function automatic logic [35:0] wexp(input logic [3:0] idx, input logic [7:0] b);
        return {idx, 8'(b + 8'd3), 8'(b + 8'd2), 8'(b + 8'd1), b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] base, input int n, input int full_at,
                        input int abort_at, input int start_at);
        for (int i = 0; i < n; i++) begin
            din       = 8'(base + 8'(i));
            fifo_full = (i == full_at);
            abort     = (i == abort_at);
            start     = (i == start_at);
            tick();
        end
        din = 8'h00; fifo_full = 1'b0; abort = 1'b0; start = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int k;
        k = 0;
        while (n_done == base && k < 40) begin
            tick();
            k++;
        end
        check_val("done_count", 64'(n_done - base), 64'd1);
    endtask

    task automatic check_zero(input string pfx);
        check_val({pfx, "_data_out"}, 64'(data_out), 64'h0);
        check_val({pfx, "_wr_en"}, 64'(fifo_wr_en), 64'h0);
        check_val({pfx, "_busy"}, 64'(busy), 64'h0);
        check_val({pfx, "_done"}, 64'(done), 64'h0);
        check_val({pfx, "_tflag"}, 64'(timeout_flag), 64'h0);
        check_val({pfx, "_drop"}, 64'(drop_cnt), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, w0, d0;

        #2;
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        tick(); tick();

        // immediate capture, incrementing data, stray start while busy
        exp_q.push_back(36'h0_03020100);
        exp_q.push_back(36'h1_07060504);
        exp_q.push_back(36'h2_0B0A0908);
        wr_cyc.delete(); w0 = n_wr; d0 = n_done;
        go(1'b1); c0 = cyc;
        check_val("a_busy", 64'(busy), 64'd1);
        feed(8'h00, 12, -1, -1, 5);
        wait_done(d0);
        check_val("a_writes", 64'(n_wr - w0), 64'd3);
        if (wr_cyc.size() >= 3) begin
            check_val("a_first_lat", 64'(wr_cyc[0] - c0), 64'd4);
            check_val("a_gap1", 64'(wr_cyc[1] - wr_cyc[0]), 64'd4);
            check_val("a_gap2", 64'(wr_cyc[2] - wr_cyc[1]), 64'd4);
            check_val("a_done_lat", 64'(done_cyc - wr_cyc[2]), 64'd1);
        end
        check_val("a_busy_end", 64'(busy), 64'd0);
        check_val("a_data_hold", 64'(data_out), 64'h2_0B0A0908);

        // header search: lone header byte must not trigger
        exp_q.push_back(wexp(4'd0, 8'h11));
        exp_q.push_back(wexp(4'd1, 8'h15));
        exp_q.push_back(wexp(4'd2, 8'h19));
        wr_cyc.delete(); w0 = n_wr; d0 = n_done;
        go(1'b0); c0 = cyc;
        din = 8'h5A; tick();
        din = 8'h22; tick();
        din = 8'h5A; tick();
        check_val("b_no_early_write", 64'(n_wr - w0), 64'd0);
        din = 8'h5A; tick();
        feed(8'h11, 12, -1, -1, -1);
        wait_done(d0);
        check_val("b_writes", 64'(n_wr - w0), 64'd3);
        if (wr_cyc.size() >= 1) check_val("b_first_lat", 64'(wr_cyc[0] - c0), 64'd8);
        check_val("b_tflag", 64'(timeout_flag), 64'd0);

        // fifo full during second word completion
        exp_q.push_back(wexp(4'd0, 8'h40));
        exp_q.push_back(wexp(4'd2, 8'h48));
        w0 = n_wr; d0 = n_done;
        go(1'b1); c0 = cyc;
        feed(8'h40, 12, 7, -1, -1);
        wait_done(d0);
        check_val("c_writes", 64'(n_wr - w0), 64'd2);
        check_val("c_drop", 64'(drop_cnt), 64'd1);
        check_val("c_done_cycle", 64'(done_cyc - c0), 64'd13);

        // search timeout with no header
        w0 = n_wr; d0 = n_done;
        din = 8'h00;
        go(1'b0); c0 = cyc;
        wait_done(d0);
        check_val("d_done_cycle", 64'(done_cyc - c0), 64'd10);
        check_val("d_tflag", 64'(timeout_flag), 64'd1);
        check_val("d_writes", 64'(n_wr - w0), 64'd0);

        // abort on the same edge a word completes
        w0 = n_wr; d0 = n_done;
        go(1'b1);
        check_val("e_tflag_cleared", 64'(timeout_flag), 64'd0);
        check_val("e_drop_cleared", 64'(drop_cnt), 64'd0);
        feed(8'h60, 4, -1, 3, -1);
        check_val("e_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 20; i++) tick();
        check_val("e_writes", 64'(n_wr - w0), 64'd0);
        check_val("e_done", 64'(n_done - d0), 64'd0);

        // async reset mid-capture, then restart
        go(1'b1);
        feed(8'h70, 6, 3, -1, -1);
        check_val("f_drop_pre", 64'(drop_cnt), 64'd1);
        rst = 1'b0;
        #2;
        check_zero("f_reset");
        tick(); tick();
        rst = 1'b1;
        w0 = n_wr; d0 = n_done;
        for (int i = 0; i < 12; i++) tick();
        check_val("f_idle_writes", 64'(n_wr - w0), 64'd0);
        check_val("f_idle_done", 64'(n_done - d0), 64'd0);
        exp_q.push_back(wexp(4'd0, 8'h80));
        exp_q.push_back(wexp(4'd1, 8'h84));
        exp_q.push_back(wexp(4'd2, 8'h88));
        go(1'b1);
        feed(8'h80, 12, -1, -1, -1);
        wait_done(d0);
        check_val("f_writes", 64'(n_wr - w0), 64'd3);

        check_val("leftover_expected", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/pixel_data_packer.md
PIXEL_DATA_PACKER -- requirements
Module: pixel_data_packer

Interface
REQ-001 Parameter NCH, default 8, number of parallel digital input channels sampled per clock (1..32).
REQ-002 Parameter FIFO_WIDTH, default 36, width of data_out; (FIFO_WIDTH-4) >= NCH.
REQ-003 Parameter NDATA, default 100, number of words produced per acquisition (1..65535).
REQ-004 Parameter HEADER, default 8'h5A (NCH bits), header sample pattern.
REQ-005 Parameter HDR_REPEAT, default 2, consecutive matching samples that form a header (1..15).
REQ-006 Parameter TIMEOUT, default 0, SEARCH timeout in cycles; 0 disables the timeout.
REQ-007 clk  input  1  system clock; all logic on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-low.
REQ-009 start  input  1  one-cycle pulse, begins acquisition.
REQ-010 abort  input  1  terminates acquisition.
REQ-011 mode  input  1  0 = header-triggered, 1 = immediate capture.
REQ-012 din  input  NCH  parallel channel samples, one sample per clk.
REQ-013 fifo_full  input  1  downstream FIFO full.
REQ-014 fifo_wr_en  output  1  one-cycle write strobe.
REQ-015 data_out  output  FIFO_WIDTH  packed word.
REQ-016 busy  output  1  high in SEARCH or CAPTURE.
REQ-017 done  output  1  one-cycle pulse at end of acquisition.
REQ-018 timeout_flag  output  1  last acquisition ended by timeout.
REQ-019 drop_cnt  output  16  words dropped due to fifo_full, saturating at 16'hFFFF.

Function
REQ-020 The block SHALL implement states IDLE, SEARCH, CAPTURE, DONE.
REQ-021 IDLE: start=1 with mode=0 -> SEARCH; start=1 with mode=1 -> CAPTURE; start SHALL clear drop_cnt and timeout_flag.
REQ-022 SEARCH: after HDR_REPEAT consecutive cycles with din==HEADER -> CAPTURE; header samples SHALL NOT be stored; the first captured sample is din on the following edge.
REQ-023 SEARCH: if TIMEOUT!=0 and TIMEOUT cycles elapse without a header -> DONE with timeout_flag=1 and no words produced.
REQ-024 SPW = (FIFO_WIDTH-4)/NCH samples per word (integer division); default SPW=4.
REQ-025 Sample i of a word (i=0..SPW-1) SHALL occupy data_out[i*NCH +: NCH]; bits [FIFO_WIDTH-5 : SPW*NCH] SHALL be 0; bits [FIFO_WIDTH-1 : FIFO_WIDTH-4] SHALL carry the word index modulo 16, starting at 0 per acquisition.
REQ-026 On the edge capturing sample SPW-1, data_out SHALL load the completed word and fifo_wr_en SHALL be 1 for exactly the following cycle if fifo_full=0 at that edge.
REQ-027 If fifo_full=1 at that edge, the word SHALL be dropped (fifo_wr_en stays 0), drop_cnt SHALL increment, and capture SHALL continue without stalling; the word index SHALL still advance.
REQ-028 CAPTURE SHALL end after NDATA words are produced (written plus dropped) -> DONE; back-to-back words SHALL be written every SPW cycles with no gap.
REQ-029 DONE SHALL last one cycle with done=1, then -> IDLE.
REQ-030 start while busy SHALL be ignored.
REQ-031 abort=1 in SEARCH or CAPTURE SHALL, on the next edge, go to IDLE, discard any partial word, suppress fifo_wr_en and done; abort has priority over simultaneous word completion and start.
REQ-032 data_out SHALL hold its last value when no write occurs.

Reset
REQ-033 rst=0 SHALL immediately force state IDLE, fifo_wr_en=0, data_out=0, busy=0, done=0, timeout_flag=0, drop_cnt=0, and clear the sample, word and timeout counters.
REQ-034 rst asserted mid-acquisition SHALL produce no further write or done pulse after release until a new start.

Verification
REQ-035 mode=1, NDATA=3, din incrementing 8'h00.. -> 3 writes: 36'h0_03020100, 36'h1_07060504, 36'h2_0B0A0908, spaced 4 cycles; done pulses 1 cycle after the third.
REQ-036 mode=0, din=8'h5A,8'h5A,then 8'h11.. -> first word payload starts 8'h11; single 8'h5A followed by other data SHALL NOT trigger capture.
REQ-037 fifo_full=1 during the second word completion, NDATA=3 -> 2 writes (index 0 and 2), drop_cnt=1, done after 12 captured samples.
REQ-038 TIMEOUT=10, mode=0, no header -> done and timeout_flag=1 exactly 10 cycles after entering SEARCH, zero writes.
REQ-039 abort on the same edge a word completes -> no write, busy=0 next cycle, no done.
REQ-040 rst=0 during CAPTURE -> all outputs zero asynchronously; subsequent start with mode=1 yields word index restarting at 0.
